// File: rtl/cpu_pkg.sv
// Shared encodings for the EX/MEM branch resolution logic.
package cpu_pkg;

  typedef enum logic [3:0] {
    BR_BGEZ = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BGTZ = 4'd3,
    BR_BLEZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_J    = 4'd6,
    BR_JR   = 4'd7,
    BR_JAL  = 4'd8
  } br_sel_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'd0,
    PCSRC_TGT  = 2'd1,
    PCSRC_FALL = 2'd2
  } pcsrc_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution: signed compare, prediction check, one-cycle
// PC redirect and a fixed-length flush window that stalls EX.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     FLUSH_STAGES = 2,
  parameter int unsigned     CNT_W        = 16,
  parameter logic [XLEN-1:0] TRAP_VEC     = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  output logic              Ready,
  input  logic [3:0]        BranchSel,
  input  logic              Zero,
  input  logic [XLEN-1:0]   ALUResult,
  input  logic [XLEN-1:0]   AddResult,
  input  logic [XLEN-5:0]   Imm,
  input  logic [XLEN-1:0]   PCPlus4,
  input  logic              PredTaken,
  output logic [1:0]        PCSrc,
  output logic [XLEN-1:0]   PCNew,
  output logic              Flush,
  output logic [CNT_W-1:0]  TakenCount,
  output logic [CNT_W-1:0]  MispredCount
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_STAGES - 1);

  bru_state_e      r_state, w_state_nxt;
  logic [2:0]      r_flush_cnt, w_flush_cnt_nxt;
  pcsrc_e          r_pcsrc, w_pcsrc_nxt;
  logic [XLEN-1:0] r_pcnew, w_pcnew_nxt;

  logic            w_accept, w_taken, w_illegal, w_redirect;
  logic            w_neg, w_zero_val;
  logic [XLEN-1:0] w_target;

  assign w_neg      = ALUResult[XLEN-1];
  assign w_zero_val = ~|ALUResult;

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    w_target  = AddResult;
    case (BranchSel)
      BR_BGEZ: w_taken = ~w_neg;
      BR_BEQ:  w_taken = Zero;
      BR_BNE:  w_taken = ~Zero;
      BR_BGTZ: w_taken = ~w_neg & ~w_zero_val;
      BR_BLEZ: w_taken = w_neg | w_zero_val;
      BR_BLTZ: w_taken = w_neg;
      BR_J: begin
        w_taken  = 1'b1;
        w_target = {AddResult[XLEN-1:XLEN-4], Imm};
      end
      BR_JR: begin
        w_taken  = 1'b1;
        w_target = ALUResult;
      end
      BR_JAL:  w_taken = 1'b1;
      default: begin
        w_illegal = 1'b1;
        w_target  = TRAP_VEC;
      end
    endcase
  end

  // Illegal codes always redirect; legal ones only when outcome != prediction.
  assign w_redirect = w_illegal | (w_taken ^ PredTaken);

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pcsrc_nxt     = PCSRC_SEQ;
    w_pcnew_nxt     = '0;
    w_accept        = 1'b0;
    Ready           = 1'b0;
    Flush           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        Ready    = 1'b1;
        w_accept = Valid;
        if (Valid && w_redirect) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
          if (w_illegal || w_taken) begin
            w_pcsrc_nxt = PCSRC_TGT;
            w_pcnew_nxt = w_target;
          end else begin
            w_pcsrc_nxt = PCSRC_FALL;
            w_pcnew_nxt = PCPlus4;
          end
        end
      end
      ST_FLUSH: begin
        Flush = 1'b1;
        if (r_flush_cnt == 3'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_pcsrc     <= PCSRC_SEQ;
      r_pcnew     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_pcsrc     <= w_pcsrc_nxt;
      r_pcnew     <= w_pcnew_nxt;
    end
  end

  assign PCSrc = r_pcsrc;
  assign PCNew = r_pcnew;

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_inc   (w_accept && w_taken && !w_illegal),
    .i_clr   (1'b0),
    .o_count (TakenCount)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_inc   (w_accept && w_redirect),
    .i_clr   (1'b0),
    .o_count (MispredCount)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a CNT_W=4 copy shares the stimulus.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  sel;
  logic        zero;
  logic [31:0] alu, add, pc4;
  logic [27:0] imm;
  logic        pred;

  logic        ready, flush;
  logic [1:0]  pcsrc;
  logic [31:0] pcnew;
  logic [15:0] tk_cnt, mp_cnt;

  logic        ready4, flush4;
  logic [1:0]  pcsrc4;
  logic [31:0] pcnew4;
  logic [3:0]  tk_cnt4, mp_cnt4;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN(32), .FLUSH_STAGES(2), .CNT_W(16), .TRAP_VEC(32'h8000_0180)
  ) u_dut (
    .Clk(clk), .Reset(rst), .Valid(valid), .Ready(ready), .BranchSel(sel),
    .Zero(zero), .ALUResult(alu), .AddResult(add), .Imm(imm), .PCPlus4(pc4),
    .PredTaken(pred), .PCSrc(pcsrc), .PCNew(pcnew), .Flush(flush),
    .TakenCount(tk_cnt), .MispredCount(mp_cnt)
  );

  branch_resolve_unit #(
    .XLEN(32), .FLUSH_STAGES(2), .CNT_W(4), .TRAP_VEC(32'h8000_0180)
  ) u_dut4 (
    .Clk(clk), .Reset(rst), .Valid(valid), .Ready(ready4), .BranchSel(sel),
    .Zero(zero), .ALUResult(alu), .AddResult(add), .Imm(imm), .PCPlus4(pc4),
    .PredTaken(pred), .PCSrc(pcsrc4), .PCNew(pcnew4), .Flush(flush4),
    .TakenCount(tk_cnt4), .MispredCount(mp_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; presents one instruction and returns at accept edge + 1.
  task automatic send(input logic [3:0] s, input logic z, input logic [31:0] a,
                      input logic [31:0] ad, input logic [27:0] im,
                      input logic [31:0] p4, input logic pr, input bit hold);
    sel = s; zero = z; alu = a; add = ad; imm = im; pc4 = p4; pred = pr;
    valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 10 && !ready; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sel = '0; zero = 1'b0;
    alu = '0; add = '0; imm = '0; pc4 = '0; pred = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcsrc", 32'(pcsrc), 32'd0);
    chk("rst_pcnew", pcnew, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_taken", 32'(tk_cnt), 32'd0);
    chk("rst_mispred", 32'(mp_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // beq taken, predicted not taken
    send(4'd1, 1'b1, 32'd0, 32'h0040_0040, 28'd0, 32'h0040_0004, 1'b0, 1'b0);
    chk("beq_pcsrc", 32'(pcsrc), 32'd1);
    chk("beq_pcnew", pcnew, 32'h0040_0040);
    chk("beq_flush0", 32'(flush), 32'd1);
    chk("beq_ready0", 32'(ready), 32'd0);
    chk("beq_mispred", 32'(mp_cnt), 32'd1);
    chk("beq_taken", 32'(tk_cnt), 32'd1);
    @(posedge clk); #1;
    chk("beq_pcsrc_clr", 32'(pcsrc), 32'd0);
    chk("beq_pcnew_clr", pcnew, 32'd0);
    chk("beq_flush1", 32'(flush), 32'd1);
    chk("beq_ready1", 32'(ready), 32'd0);
    @(posedge clk); #1;
    chk("beq_flush2", 32'(flush), 32'd0);
    chk("beq_ready2", 32'(ready), 32'd1);

    // bltz: -1 is taken (correctly predicted), INT_MAX is not taken
    send(4'd5, 1'b0, 32'hFFFF_FFFF, 32'h0000_0800, 28'd0, 32'h0040_0104, 1'b1, 1'b0);
    chk("bltz_neg_pcsrc", 32'(pcsrc), 32'd0);
    chk("bltz_neg_flush", 32'(flush), 32'd0);
    chk("bltz_neg_taken", 32'(tk_cnt), 32'd2);
    send(4'd5, 1'b0, 32'h7FFF_FFFF, 32'h0000_0800, 28'd0, 32'h0040_0104, 1'b1, 1'b0);
    chk("bltz_pos_pcsrc", 32'(pcsrc), 32'd2);
    chk("bltz_pos_pcnew", pcnew, 32'h0040_0104);
    chk("bltz_pos_taken", 32'(tk_cnt), 32'd2);
    chk("bltz_pos_mispred", 32'(mp_cnt), 32'd2);
    wait_idle("bltz_idle");

    // j and jr targets
    send(4'd6, 1'b0, 32'd0, 32'hA000_0000, 28'h000_0100, 32'd0, 1'b0, 1'b0);
    chk("j_pcsrc", 32'(pcsrc), 32'd1);
    chk("j_pcnew", pcnew, 32'hA000_0100);
    chk("j_taken", 32'(tk_cnt), 32'd3);
    wait_idle("j_idle");
    send(4'd7, 1'b0, 32'h0000_1234, 32'h5555_5550, 28'd0, 32'd0, 1'b0, 1'b0);
    chk("jr_pcnew", pcnew, 32'h0000_1234);
    chk("jr_mispred", 32'(mp_cnt), 32'd4);
    wait_idle("jr_idle");

    // back-to-back correctly predicted branches, including the zero boundary
    send(4'd3, 1'b0, 32'd5, 32'h100, 28'd0, 32'h4, 1'b1, 1'b1);
    chk("b2b_bgtz_taken", 32'(tk_cnt), 32'd5);
    chk("b2b_bgtz_ready", 32'(ready), 32'd1);
    send(4'd0, 1'b0, 32'd0, 32'h100, 28'd0, 32'h4, 1'b1, 1'b1);
    chk("b2b_bgez0_taken", 32'(tk_cnt), 32'd6);
    send(4'd4, 1'b0, 32'd1, 32'h100, 28'd0, 32'h4, 1'b0, 1'b0);
    chk("b2b_blez1_taken", 32'(tk_cnt), 32'd6);
    chk("b2b_pcsrc", 32'(pcsrc), 32'd0);
    chk("b2b_mispred", 32'(mp_cnt), 32'd4);

    // illegal code, Valid held through the flush with a would-redirect jal
    send(4'd12, 1'b0, 32'd0, 32'h100, 28'd0, 32'h4, 1'b1, 1'b1);
    chk("ill_pcsrc", 32'(pcsrc), 32'd1);
    chk("ill_pcnew", pcnew, 32'h8000_0180);
    chk("ill_mispred", 32'(mp_cnt), 32'd5);
    chk("ill_taken", 32'(tk_cnt), 32'd6);
    sel = 4'd8; pred = 1'b0; add = 32'h55;
    @(posedge clk); #1;
    chk("ill_hold_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("ill_hold_pcsrc", 32'(pcsrc), 32'd0);
    chk("ill_hold_mispred", 32'(mp_cnt), 32'd5);
    chk("ill_hold_taken", 32'(tk_cnt), 32'd6);
    chk("ill_hold_ready1", 32'(ready), 32'd1);

    // reset in the middle of a flush
    send(4'd1, 1'b1, 32'd0, 32'h0040_0040, 28'd0, 32'h4, 1'b0, 1'b0);
    chk("mid_flush_on", 32'(flush), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_flush", 32'(flush), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_pcsrc", 32'(pcsrc), 32'd0);
    chk("mid_rst_mispred", 32'(mp_cnt), 32'd0);
    chk("mid_rst_taken", 32'(tk_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 20 mispredicted jals: 16-bit counters count, 4-bit counters saturate
    for (int n = 0; n < 20; n++) begin
      send(4'd8, 1'b0, 32'd0, 32'h100, 28'd0, 32'h4, 1'b0, 1'b0);
      wait_idle("sat_idle");
    end
    chk("sat16_mispred", 32'(mp_cnt), 32'd20);
    chk("sat16_taken", 32'(tk_cnt), 32'd20);
    chk("sat4_mispred", 32'(mp_cnt4), 32'hF);
    chk("sat4_taken", 32'(tk_cnt4), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
